// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: FSM states, grant owner and lane count.
package mem_arb_pkg;

   localparam int unsigned LANES = 4;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RESP,
      RMW_MERGE
   } state_t;

   typedef enum logic {
      GRANT_IF,
      GRANT_D
   } grant_t;

endpackage

// File: rtl/mem_byte_merge.sv
// Per-lane merge of new store data over the old memory word (combinational).
module mem_byte_merge
   import mem_arb_pkg::*;
(
   input  logic [LANES*8-1:0] old_word,
   input  logic [LANES*8-1:0] new_word,
   input  logic [LANES-1:0]   be,
   output logic [LANES*8-1:0] merged
);

   always_comb begin
      merged = old_word;
      for (int k = 0; k < int'(LANES); k++) begin
         if (be[k]) merged[8*k +: 8] = new_word[8*k +: 8];
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-cycle-read BRAM between instruction
// fetch and the load/store port; sub-word stores become read-modify-write.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned WORDS      = 10,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  if_req_i,
   input  logic [WORDS+1:0]      if_addr_i,
   output logic                  if_ack_o,
   output logic [DATA_WIDTH-1:0] if_rdata_o,
   input  logic                  d_req_i,
   input  logic                  d_we_i,
   input  logic [LANES-1:0]      d_be_i,
   input  logic [WORDS+1:0]      d_addr_i,
   input  logic [DATA_WIDTH-1:0] d_wdata_i,
   output logic                  d_ack_o,
   output logic [DATA_WIDTH-1:0] d_rdata_o,
   output logic [WORDS-1:0]      mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_data_o,
   output logic                  mem_wr_n_o,
   output logic                  mem_rd_n_o,
   input  logic [DATA_WIDTH-1:0] mem_data_i
);

   state_t                state;
   grant_t                grant;
   grant_t                last_grant;
   logic                  we;
   logic [LANES-1:0]      be;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH-1:0] if_rdata;
   logic [DATA_WIDTH-1:0] d_rdata;
   logic [DATA_WIDTH-1:0] merged;
   logic                  partial;
   logic                  pick_if;
   logic                  unused_addr_lsbs;

   assign unused_addr_lsbs = ^{if_addr_i[1:0], d_addr_i[1:0]};

   assign partial = we && (be != '0) && (be != '1);
   // Fetch wins if alone, or on a tie when data was served last.
   assign pick_if = if_req_i && (!d_req_i || (last_grant == GRANT_D));

   mem_byte_merge u_merge (
      .old_word (mem_data_i),
      .new_word (wdata),
      .be       (be),
      .merged   (merged)
   );

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state      <= IDLE;
         grant      <= GRANT_IF;
         last_grant <= GRANT_D;
         we         <= 1'b0;
         be         <= '0;
         wdata      <= '0;
         if_ack_o   <= 1'b0;
         d_ack_o    <= 1'b0;
         if_rdata   <= '0;
         d_rdata    <= '0;
         mem_addr_o <= '0;
         mem_data_o <= '0;
         mem_wr_n_o <= 1'b1;
         mem_rd_n_o <= 1'b1;
      end else begin
         if_ack_o   <= 1'b0;
         d_ack_o    <= 1'b0;
         mem_wr_n_o <= 1'b1;
         mem_rd_n_o <= 1'b1;
         case (state)
            IDLE: begin
               if (pick_if) begin
                  grant      <= GRANT_IF;
                  we         <= 1'b0;
                  be         <= '0;
                  mem_addr_o <= if_addr_i[WORDS+1:2];
                  mem_rd_n_o <= 1'b0;
                  state      <= ISSUE;
               end else if (d_req_i) begin
                  grant      <= GRANT_D;
                  we         <= d_we_i;
                  be         <= d_be_i;
                  wdata      <= d_wdata_i;
                  mem_addr_o <= d_addr_i[WORDS+1:2];
                  // Full stores write directly; partial ones read the old word first.
                  if (!d_we_i || (d_be_i != '1 && d_be_i != '0)) begin
                     mem_rd_n_o <= 1'b0;
                  end else if (d_be_i == '1) begin
                     mem_wr_n_o <= 1'b0;
                     mem_data_o <= d_wdata_i;
                  end
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               if (partial) begin
                  state <= RMW_MERGE;
               end else begin
                  if_ack_o <= (grant == GRANT_IF);
                  d_ack_o  <= (grant == GRANT_D);
                  state    <= RESP;
               end
            end
            RMW_MERGE: begin
               mem_data_o <= merged;
               mem_wr_n_o <= 1'b0;
               d_ack_o    <= 1'b1;
               state      <= RESP;
            end
            RESP: begin
               if (grant == GRANT_IF) if_rdata <= mem_data_i;
               else if (!we)          d_rdata  <= mem_data_i;
               last_grant <= grant;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Memory data is only valid during RESP, so the ack cycle bypasses the holding register.
   assign if_rdata_o = if_ack_o ? mem_data_i : if_rdata;
   assign d_rdata_o  = (d_ack_o && !we) ? mem_data_i : d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: mem_arbiter wired to a behavioural BRAM with static content.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int unsigned WORDS = 10;
   localparam int unsigned AW    = WORDS + 2;
   localparam int unsigned DW    = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic          if_ack;
   logic [DW-1:0] if_rdata;
   logic          d_req = 1'b0;
   logic          d_we = 1'b0;
   logic [3:0]    d_be = '0;
   logic [AW-1:0] d_addr = '0;
   logic [DW-1:0] d_wdata = '0;
   logic          d_ack;
   logic [DW-1:0] d_rdata;
   logic [WORDS-1:0] mem_addr;
   logic [DW-1:0] mem_data_o;
   logic          mem_wr_n;
   logic          mem_rd_n;
   logic [DW-1:0] mem_q = '0;

   logic [DW-1:0] mem [0:(1<<WORDS)-1];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.WORDS(WORDS), .DATA_WIDTH(DW)) dut (
      .clk_i      (clk),
      .reset_i    (reset),
      .if_req_i   (if_req),
      .if_addr_i  (if_addr),
      .if_ack_o   (if_ack),
      .if_rdata_o (if_rdata),
      .d_req_i    (d_req),
      .d_we_i     (d_we),
      .d_be_i     (d_be),
      .d_addr_i   (d_addr),
      .d_wdata_i  (d_wdata),
      .d_ack_o    (d_ack),
      .d_rdata_o  (d_rdata),
      .mem_addr_o (mem_addr),
      .mem_data_o (mem_data_o),
      .mem_wr_n_o (mem_wr_n),
      .mem_rd_n_o (mem_rd_n),
      .mem_data_i (mem_q)
   );

   // Standalone merge unit
   logic [31:0] m_old, m_new, m_out;
   logic [3:0]  m_be;
   mem_byte_merge u_merge_ut (.old_word(m_old), .new_word(m_new), .be(m_be), .merged(m_out));

   // Behavioural Memory: active-low strobes, registered read
   initial begin
      for (int i = 0; i < (1 << WORDS); i++) mem[i] = 32'(i * 3);
      mem[10] = 32'h55AA_3312;
      mem[14] = 32'hBBAA_1136;
      mem[18] = 32'hD0B0_A090;
   end

   always @(posedge clk) begin
      if (!mem_wr_n) mem[mem_addr] <= mem_data_o;
      if (!mem_rd_n) mem_q <= mem[mem_addr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One transaction on one port; lat counts negedges from the IDLE accept cycle to ack.
   task automatic run(input bit is_if, input bit we, input logic [3:0] be,
                      input logic [AW-1:0] addr, input logic [31:0] wdata,
                      output logic [31:0] data, output int lat,
                      output logic [7:0] rdtr, output logic [7:0] wrtr,
                      output logic [31:0] mdata);
      bit got_ack;
      @(negedge clk);
      if (is_if) begin
         if_req = 1'b1; if_addr = addr;
      end else begin
         d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wdata;
      end
      lat = 0; rdtr = '0; wrtr = '0; data = '0; mdata = '0; got_ack = 1'b0;
      while (!got_ack && lat < 16) begin
         @(negedge clk);
         lat++;
         if (lat < 8) begin
            rdtr[lat] = !mem_rd_n;
            wrtr[lat] = !mem_wr_n;
         end
         if (is_if ? if_ack : d_ack) begin
            got_ack = 1'b1;
            data    = is_if ? if_rdata : d_rdata;
            mdata   = mem_data_o;
         end
      end
      if_req = 1'b0;
      d_req  = 1'b0;
      if (!got_ack) check("ack_timeout", 32'(lat), 32'd0);
   endtask

   logic [31:0] data, mdata;
   logic [7:0]  rdtr, wrtr;
   int          lat;

   initial begin
      // Merge unit vectors
      m_old = 32'h1122_3344; m_new = 32'hAABB_CCDD;
      m_be = 4'b0101; #1 check("merge_0101", m_out, 32'h11BB_33DD);
      m_be = 4'b1010; #1 check("merge_1010", m_out, 32'hAA22_CC44);
      m_be = 4'b0000; #1 check("merge_0000", m_out, 32'h1122_3344);
      m_be = 4'b1111; #1 check("merge_1111", m_out, 32'hAABB_CCDD);

      reset = 1'b1;
      @(negedge clk);
      check("rst_if_ack", 32'(if_ack), 32'd0);
      check("rst_d_ack", 32'(d_ack), 32'd0);
      check("rst_if_rdata", if_rdata, 32'd0);
      check("rst_d_rdata", d_rdata, 32'd0);
      check("rst_wr_n", 32'(mem_wr_n), 32'd1);
      check("rst_rd_n", 32'(mem_rd_n), 32'd1);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_data", mem_data_o, 32'd0);
      reset = 1'b0;

      // Continuous contention from reset: IF, D, IF, D with acks every 3 cycles
      begin
         int nack = 0;
         int cyc = 0;
         @(negedge clk);
         if_req = 1'b1; if_addr = 12'h008;
         d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 12'h028; d_wdata = '0;
         while (nack < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (if_ack && d_ack) check("ack_overlap", 32'd1, 32'd0);
            if (if_ack || d_ack) begin
               check($sformatf("grant%0d_port", nack), 32'(d_ack), 32'(nack % 2));
               check($sformatf("grant%0d_cycle", nack), 32'(cyc), 32'(2 + 3 * nack));
               check($sformatf("grant%0d_rdata", nack), d_ack ? d_rdata : if_rdata,
                     d_ack ? 32'h55AA_3312 : 32'h0000_0006);
               nack++;
            end
         end
         if_req = 1'b0; d_req = 1'b0;
         check("contention_acks", 32'(nack), 32'd4);
      end

      // Fetch alone
      run(1'b1, 1'b0, 4'h0, 12'h008, 32'h0, data, lat, rdtr, wrtr, mdata);
      check("fetch_rdata", data, 32'h0000_0006);
      check("fetch_lat", 32'(lat), 32'd2);

      // Load, no write strobe
      run(1'b0, 1'b0, 4'hF, 12'h028, 32'h0, data, lat, rdtr, wrtr, mdata);
      check("load28_rdata", data, 32'h55AA_3312);
      check("load28_lat", 32'(lat), 32'd2);
      check("load28_rd_trace", 32'(rdtr), 32'h02);
      check("load28_wr_trace", 32'(wrtr), 32'h00);

      // Full store then read-back; d_rdata holds the previous load across the store
      run(1'b0, 1'b1, 4'hF, 12'h030, 32'hDEAD_BEEF, data, lat, rdtr, wrtr, mdata);
      check("store30_lat", 32'(lat), 32'd2);
      check("store30_wr_trace", 32'(wrtr), 32'h02);
      check("store30_rd_trace", 32'(rdtr), 32'h00);
      check("store30_rdata_hold", data, 32'h55AA_3312);
      run(1'b0, 1'b0, 4'hF, 12'h030, 32'h0, data, lat, rdtr, wrtr, mdata);
      check("load30_rdata", data, 32'hDEAD_BEEF);

      // Store with no lanes enabled: no memory access at all
      run(1'b0, 1'b1, 4'h0, 12'h030, 32'h1234_5678, data, lat, rdtr, wrtr, mdata);
      check("store_be0_lat", 32'(lat), 32'd2);
      check("store_be0_strobes", 32'({rdtr, wrtr}), 32'h0000);
      run(1'b0, 1'b0, 4'hF, 12'h030, 32'h0, data, lat, rdtr, wrtr, mdata);
      check("load30_after_be0", data, 32'hDEAD_BEEF);

      // Partial store: read in ISSUE, merged write presented with the ack
      run(1'b0, 1'b1, 4'b0010, 12'h038, 32'h0000_EE00, data, lat, rdtr, wrtr, mdata);
      check("rmw38_lat", 32'(lat), 32'd3);
      check("rmw38_rd_trace", 32'(rdtr), 32'h02);
      check("rmw38_wr_trace", 32'(wrtr), 32'h08);
      check("rmw38_merged", mdata, 32'hBBAA_EE36);
      run(1'b0, 1'b0, 4'hF, 12'h038, 32'h0, data, lat, rdtr, wrtr, mdata);
      check("load38_rdata", data, 32'hBBAA_EE36);

      // Fetch at top word with nonzero address lsbs
      run(1'b1, 1'b0, 4'h0, 12'hFFF, 32'h0, data, lat, rdtr, wrtr, mdata);
      check("fetch_top_rdata", data, 32'h0000_0BFD);

      // Reset during RMW_MERGE of a store to 0x48
      begin
         int seen = 0;
         @(negedge clk);
         d_req = 1'b1; d_we = 1'b1; d_be = 4'b0001; d_addr = 12'h048; d_wdata = 32'h0000_00FF;
         @(negedge clk);
         check("rmw48_issue_rd_n", 32'(mem_rd_n), 32'd0);
         @(negedge clk);
         reset = 1'b1;
         d_req = 1'b0;
         #1;
         check("rmw48_rst_addr", 32'(mem_addr), 32'd0);
         check("rmw48_rst_wr_n", 32'(mem_wr_n), 32'd1);
         check("rmw48_rst_rd_n", 32'(mem_rd_n), 32'd1);
         check("rmw48_rst_data", mem_data_o, 32'd0);
         check("rmw48_rst_d_rdata", d_rdata, 32'd0);
         @(negedge clk);
         @(negedge clk);
         reset = 1'b0;
         for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (d_ack || if_ack) seen++;
         end
         check("rmw48_no_ack", 32'(seen), 32'd0);
         run(1'b0, 1'b0, 4'hF, 12'h048, 32'h0, data, lat, rdtr, wrtr, mdata);
         check("load48_unchanged", data, 32'hD0B0_A090);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
